apb_rr_master: RTL

//  APB master that shares one APB slave (e.g. the 8-bit register/memory slave) among NUM_REQ

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_rr_arbiter.sv | 36 +++
 rtl/apb_rr_master.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: phase encoding used by both this master and the slave.
package apb_pkg;

  // APB phase encoding: IDLE, SETUP (psel only), ACCESS (psel + penable)
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b11
  } apb_state_e;

  // Width of a requester index; a single bit minimum so ports never collapse
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after the pointer, wrapping.
module apb_rr_arbiter
  import apb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_WD   = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_WD-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_WD-1:0]   grant_id,
  output logic               grant_any
);

  // Two passes: indices above the pointer first, then wrap to the ones at or below it
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req[i] && (i > int'(ptr))) begin
        grant_any = 1'b1;
        grant[i]  = 1'b1;
        grant_id  = ID_WD'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req[i] && (i <= int'(ptr))) begin
        grant_any = 1'b1;
        grant[i]  = 1'b1;
        grant_id  = ID_WD'(i);
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB master shared by NUM_REQ requesters: round-robin accept, SETUP/ACCESS sequencing,
// pready timeout and one tagged response per accepted command.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int DATA_WD = 8,
  parameter  int ADDR_WD = 8,
  parameter  int TIMEOUT = 16,
  localparam int ID_WD   = id_width(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_WD-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WD-1:0] req_wdata,
  output logic                       rsp_valid,
  output logic [ID_WD-1:0]           rsp_id,
  output logic [DATA_WD-1:0]         rsp_rdata,
  output logic                       rsp_err,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [ADDR_WD-1:0]         paddr,
  output logic [DATA_WD-1:0]         pwdata,
  input  logic [DATA_WD-1:0]         prdata,
  input  logic                       pready
);

  localparam int CNT_WD = $clog2(TIMEOUT + 1);

  apb_state_e          state;
  logic [ID_WD-1:0]    rr_ptr;
  logic [ID_WD-1:0]    cur_id;
  logic [CNT_WD-1:0]   wait_cnt;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_WD-1:0]    grant_id;
  logic                grant_any;

  logic                sel_write;
  logic [ADDR_WD-1:0]  sel_addr;
  logic [DATA_WD-1:0]  sel_wdata;

  logic                complete;
  logic                abort;
  logic                window;
  logic                accept;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  // A transfer ends either by pready or by running out of ACCESS cycles; the abort
  // cycle is never an accept window, so nothing new is taken on a timeout
  assign complete = (state == ACCESS) && pready;
  assign abort    = (state == ACCESS) && !pready && (wait_cnt == CNT_WD'(TIMEOUT - 1));
  assign window   = (state == IDLE) || complete;
  assign accept   = rst_n && window && grant_any;

  // Ready is held low during reset even though the state already reads IDLE
  assign req_ready = (rst_n && window) ? grant : '0;

  // Pick out the granted requester's command fields from the flattened buses
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_WD +: ADDR_WD];
        sel_wdata = req_wdata[i*DATA_WD +: DATA_WD];
      end
    end
  end

  // Phase FSM with registered bus outputs, timeout counter and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= ID_WD'(NUM_REQ - 1);
      cur_id   <= '0;
      wait_cnt <= '0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
    end else if (accept) begin
      state   <= SETUP;
      psel    <= 1'b1;
      penable <= 1'b0;
      pwrite  <= sel_write;
      paddr   <= sel_addr;
      pwdata  <= sel_wdata;
      cur_id  <= grant_id;
      rr_ptr  <= grant_id;
    end else begin
      case (state)
        SETUP: begin
          state    <= ACCESS;
          penable  <= 1'b1;
          wait_cnt <= '0;
        end
        ACCESS: begin
          if (complete || abort) begin
            state   <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

  // Response pulse one cycle after a transfer ends; data only for successful reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= complete || abort;
      if (complete || abort) begin
        rsp_id    <= cur_id;
        rsp_err   <= abort;
        rsp_rdata <= (complete && !pwrite) ? prdata : '0;
      end
    end
  end

endmodule
